// File: rtl/bin_to_bcd_pair_if.sv
// Handshake/data bundle between the LCD top level and the binary-to-BCD pair
// converter. The master drives the request and the two binary values; the
// slave (the converter) returns both digit sets, the overflow flags and status.
interface bin_to_bcd_pair_if #(
  parameter int IN_WIDTH = 16
);
  logic                iStart;
  logic [IN_WIDTH-1:0] iValue1;
  logic [IN_WIDTH-1:0] iValue2;

  logic [3:0] oThousandsBin1;
  logic [3:0] oHundredsBin1;
  logic [3:0] oTensBin1;
  logic [3:0] oOnesBin1;
  logic [3:0] oThousandsBin2;
  logic [3:0] oHundredsBin2;
  logic [3:0] oTensBin2;
  logic [3:0] oOnesBin2;
  logic       oOverflow1;
  logic       oOverflow2;
  logic       oBusy;
  logic       oDone;

  modport master (
    output iStart, iValue1, iValue2,
    input  oThousandsBin1, oHundredsBin1, oTensBin1, oOnesBin1,
    input  oThousandsBin2, oHundredsBin2, oTensBin2, oOnesBin2,
    input  oOverflow1, oOverflow2, oBusy, oDone
  );

  modport slave (
    input  iStart, iValue1, iValue2,
    output oThousandsBin1, oHundredsBin1, oTensBin1, oOnesBin1,
    output oThousandsBin2, oHundredsBin2, oTensBin2, oOnesBin2,
    output oOverflow1, oOverflow2, oBusy, oDone
  );
endinterface

// File: rtl/bin_to_bcd_pair.sv
// Sequential binary-to-BCD converter for two values (Num1, Num2).
// Each value is clamped to 9999, then converted by double dabble one bit per
// clock (14 iterations each). Value 1 is converted first and parked; both digit
// sets are published together on the final edge of the value-2 conversion so
// the display never shows a half-updated pair. A conversion is started by
// iStart or by a periodic refresh tick, and requests outside IDLE are dropped.
module bin_to_bcd_pair #(
  parameter int IN_WIDTH       = 16,
  parameter int REFRESH_CYCLES = 5000000
) (
  input logic             iCLK_50MHZ,
  input logic             iRST_N,
  bin_to_bcd_pair_if.slave bus
);

  // Clamped values never exceed 9999, so 14 bits of binary and four BCD
  // nibbles are always enough.
  localparam int                  BIN_W     = 14;
  localparam logic [3:0]          LAST_ITER = 4'(BIN_W - 1);
  localparam logic [IN_WIDTH-1:0] MAX_VAL   = IN_WIDTH'(9999);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV1 = 2'd1,
    CONV2 = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] bin_q;      // binary shift register
  logic [15:0]      bcd_q;      // BCD accumulator
  logic [3:0]       iter_q;     // iterations done in the current pass
  logic [15:0]      res1_q;     // finished value-1 digits, waiting for value 2
  logic [BIN_W-1:0] val2_q;     // clamped value 2, latched at start
  logic             ovf1_q;
  logic             ovf2_q;
  logic [31:0]      digits_q;   // {Num1 TH,H,T,O, Num2 TH,H,T,O}
  logic             ovf1_out_q;
  logic             ovf2_out_q;
  logic             busy_q;
  logic             done_q;

  logic             tick;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_d;
  logic [BIN_W-1:0] bin_d;

  // Clamp anything above 9999 (at any input width) instead of letting the
  // upper bits wrap into the 14-bit converter.
  function automatic logic [BIN_W-1:0] clamp14(input logic [IN_WIDTH-1:0] v);
    if (v > MAX_VAL) begin
      return BIN_W'(9999);
    end
    return v[BIN_W-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Periodic refresh tick: free-running counter 0..REFRESH_CYCLES-1,
  // tick high while the count sits on its last value. Zero disables it.
  // ---------------------------------------------------------------------
  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int             CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [CW-1:0]  LAST_CNT = CW'(REFRESH_CYCLES - 1);
      logic [CW-1:0] cnt_q;

      // Refresh counter, wrapping at the period boundary.
      always_ff @(posedge iCLK_50MHZ) begin
        if (!iRST_N) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign tick = (cnt_q == LAST_CNT);
    end else begin : g_no_refresh
      assign tick = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // One double-dabble step: add 3 to each nibble >= 5, then shift the
  // {BCD, binary} pair left by one.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? (bcd_q[gi*4 +: 4] + 4'd3)
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign bcd_d = {bcd_adj[14:0], bin_q[BIN_W-1]};
  assign bin_d = {bin_q[BIN_W-2:0], 1'b0};

  // Conversion sequencer: IDLE -> CONV1 (value 1) -> CONV2 (value 2) -> IDLE,
  // with all outputs registered here.
  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      res1_q     <= '0;
      val2_q     <= '0;
      ovf1_q     <= 1'b0;
      ovf2_q     <= 1'b0;
      digits_q   <= '0;
      ovf1_out_q <= 1'b0;
      ovf2_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iStart | tick) begin
            bin_q   <= clamp14(bus.iValue1);
            val2_q  <= clamp14(bus.iValue2);
            ovf1_q  <= (bus.iValue1 > MAX_VAL);
            ovf2_q  <= (bus.iValue2 > MAX_VAL);
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV1;
          end
        end

        CONV1: begin
          if (iter_q == LAST_ITER) begin
            // Park value 1 and start over on value 2.
            res1_q  <= bcd_d;
            bin_q   <= val2_q;
            bcd_q   <= '0;
            iter_q  <= '0;
            state_q <= CONV2;
          end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            iter_q <= iter_q + 4'd1;
          end
        end

        CONV2: begin
          if (iter_q == LAST_ITER) begin
            // Publish both digit sets and both flags on the same edge.
            digits_q   <= {res1_q, bcd_d};
            ovf1_out_q <= ovf1_q;
            ovf2_out_q <= ovf2_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            bcd_q      <= '0;
            bin_q      <= '0;
            iter_q     <= '0;
            state_q    <= IDLE;
          end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            iter_q <= iter_q + 4'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oThousandsBin1 = digits_q[31:28];
  assign bus.oHundredsBin1  = digits_q[27:24];
  assign bus.oTensBin1      = digits_q[23:20];
  assign bus.oOnesBin1      = digits_q[19:16];
  assign bus.oThousandsBin2 = digits_q[15:12];
  assign bus.oHundredsBin2  = digits_q[11:8];
  assign bus.oTensBin2      = digits_q[7:4];
  assign bus.oOnesBin2      = digits_q[3:0];
  assign bus.oOverflow1     = ovf1_out_q;
  assign bus.oOverflow2     = ovf2_out_q;
  assign bus.oBusy          = busy_q;
  assign bus.oDone          = done_q;

endmodule

// File: tb/tb_bin_to_bcd_pair.sv
// Bench for bin_to_bcd_pair: one instance with auto-refresh off for the
// start-driven cases, one with a 100-cycle refresh period.
module tb_bin_to_bcd_pair;

  logic clk;
  logic rst_n;
  logic rst_n_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] last_exp;

  bin_to_bcd_pair_if #(.IN_WIDTH(16)) bus ();
  bin_to_bcd_pair_if #(.IN_WIDTH(16)) bus_r ();

  bin_to_bcd_pair #(.IN_WIDTH(16), .REFRESH_CYCLES(0)) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .bus        (bus.slave)
  );

  bin_to_bcd_pair #(.IN_WIDTH(16), .REFRESH_CYCLES(100)) dut_r (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n_r),
    .bus        (bus_r.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: clamp to 9999, split into decimal digits.
  function automatic logic [33:0] model(input int v1, input int v2);
    int c1;
    int c2;
    c1 = (v1 > 9999) ? 9999 : v1;
    c2 = (v2 > 9999) ? 9999 : v2;
    return {(v1 > 9999), (v2 > 9999),
            4'(c1 / 1000), 4'((c1 / 100) % 10), 4'((c1 / 10) % 10), 4'(c1 % 10),
            4'(c2 / 1000), 4'((c2 / 100) % 10), 4'((c2 / 10) % 10), 4'(c2 % 10)};
  endfunction

  function automatic logic [33:0] pack_dut();
    return {bus.oOverflow1, bus.oOverflow2,
            bus.oThousandsBin1, bus.oHundredsBin1, bus.oTensBin1, bus.oOnesBin1,
            bus.oThousandsBin2, bus.oHundredsBin2, bus.oTensBin2, bus.oOnesBin2};
  endfunction

  function automatic logic [33:0] pack_dut_r();
    return {bus_r.oOverflow1, bus_r.oOverflow2,
            bus_r.oThousandsBin1, bus_r.oHundredsBin1, bus_r.oTensBin1, bus_r.oOnesBin1,
            bus_r.oThousandsBin2, bus_r.oHundredsBin2, bus_r.oTensBin2, bus_r.oOnesBin2};
  endfunction

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One start pulse and a full conversion. mode 1 also re-pulses iStart and
  // changes the inputs at cycle 10 (must be ignored, not queued).
  task automatic run_conv(input int v1, input int v2, input int mode);
    int          done_k;
    int          busy_cnt;
    int          hold_bad;
    int          extra;
    logic [33:0] exp;
    exp = model(v1, v2);
    @(negedge clk);
    bus.iValue1 = 16'(v1);
    bus.iValue2 = 16'(v2);
    bus.iStart  = 1'b1;
    done_k   = 0;
    busy_cnt = 0;
    hold_bad = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.iStart = 1'b0;
      if (mode == 1 && k == 10) begin
        bus.iStart  = 1'b1;
        bus.iValue1 = 16'd1111;
        bus.iValue2 = 16'd2222;
      end
      if (mode == 1 && k == 11) bus.iStart = 1'b0;
      if (bus.oDone) begin
        done_k = k;
      end else begin
        if (bus.oBusy) busy_cnt++;
        if (pack_dut() !== last_exp) hold_bad++;
      end
    end
    $display("conv %0d/%0d mode %0d: done at cycle %0d, busy %0d cycles, digits %h",
             v1, v2, mode, done_k, busy_cnt, pack_dut());
    check("latency", 34'(done_k - 1), 34'd28);
    check("busy_cycles", 34'(busy_cnt), 34'd28);
    check("hold_before_done", 34'(hold_bad), 34'd0);
    check("digits", pack_dut(), exp);
    check("busy_at_done", 34'(bus.oBusy), 34'd0);
    @(negedge clk);
    check("done_width", 34'(bus.oDone), 34'd0);
    last_exp = exp;
    if (mode == 1) begin
      extra = 0;
      for (int k = 0; k < 35; k++) begin
        @(negedge clk);
        if (bus.oDone) extra++;
      end
      check("ignored_start", 34'(extra), 34'd0);
      check("digits_after_ignore", pack_dut(), exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          v1;
    int          v2;
    int          t[3];
    int          nd;
    int          aborts;
    int          done_t[5];
    logic [33:0] exp_r[5];

    bus.iStart    = 1'b0;
    bus.iValue1   = '0;
    bus.iValue2   = '0;
    bus_r.iStart  = 1'b0;
    bus_r.iValue1 = '0;
    bus_r.iValue2 = '0;
    rst_n   = 1'b0;
    rst_n_r = 1'b0;
    last_exp = '0;

    // Reset state
    repeat (3) @(negedge clk);
    $display("reset: digits %h busy %0b done %0b", pack_dut(), bus.oBusy, bus.oDone);
    check("reset_digits", pack_dut(), 34'd0);
    check("reset_busy", 34'(bus.oBusy), 34'd0);
    check("reset_done", 34'(bus.oDone), 34'd0);
    rst_n = 1'b1;

    // Directed values, including clamp boundaries
    run_conv(1234, 9999, 0);
    run_conv(10000, 0, 0);
    run_conv(65535, 0, 0);
    run_conv(5, 0, 0);
    run_conv(16384, 10000, 0);
    run_conv(9999, 16383, 0);

    // Restart attempt and input change while busy
    run_conv(4321, 42, 1);

    // Randomized values, mixing in-range and full-width inputs
    for (int i = 0; i < 10; i++) begin
      v1 = ($urandom % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      v2 = ($urandom % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      run_conv(v1, v2, 0);
    end

    // iStart held high: one conversion every 29 cycles
    @(negedge clk);
    bus.iValue1 = 16'd3;
    bus.iValue2 = 16'd4;
    bus.iStart  = 1'b1;
    nd = 0;
    for (int k = 1; k <= 120 && nd < 3; k++) begin
      @(negedge clk);
      if (bus.oDone) begin
        t[nd] = k;
        nd++;
      end
    end
    bus.iStart = 1'b0;
    $display("back-to-back: dones at %0d %0d %0d", t[0], t[1], t[2]);
    check("b2b_count", 34'(nd), 34'd3);
    check("b2b_period1", 34'(t[1] - t[0]), 34'd29);
    check("b2b_period2", 34'(t[2] - t[1]), 34'd29);
    check("b2b_digits", pack_dut(), model(3, 4));
    repeat (40) @(negedge clk);
    last_exp = model(3, 4);

    // Reset in the middle of a conversion
    @(negedge clk);
    bus.iValue1 = 16'd5678;
    bus.iValue2 = 16'd8765;
    bus.iStart  = 1'b1;
    aborts = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.iStart = 1'b0;
      if (bus.oDone) aborts++;
      if (k == 20) rst_n = 1'b0;
      if (k == 21) begin
        $display("mid-conversion reset: digits %h busy %0b", pack_dut(), bus.oBusy);
        check("abort_digits", pack_dut(), 34'd0);
        check("abort_busy", 34'(bus.oBusy), 34'd0);
        rst_n = 1'b1;
      end
    end
    check("abort_no_done", 34'(aborts), 34'd0);
    last_exp = '0;
    run_conv(5678, 8765, 0);

    // Auto-refresh instance
    exp_r[1] = model(250, 7);
    exp_r[2] = model(1234, 10001);
    exp_r[3] = model(1234, 10001);
    exp_r[4] = model(42, 9);
    @(negedge clk);
    bus_r.iValue1 = 16'd250;
    bus_r.iValue2 = 16'd7;
    rst_n_r = 1'b1;
    nd = 0;
    for (int c = 1; c <= 600 && nd < 4; c++) begin
      @(negedge clk);
      if (bus_r.oDone) begin
        nd++;
        done_t[nd] = c;
        $display("refresh done %0d at cycle %0d: digits %h", nd, c, pack_dut_r());
        check("refresh_digits", pack_dut_r(), exp_r[nd]);
      end
      if (nd == 1 && c == done_t[1] + 40) begin
        bus_r.iValue1 = 16'd1234;
        bus_r.iValue2 = 16'd10001;
      end
      if (nd == 1 && c == done_t[1] + 60) begin
        check("refresh_hold", pack_dut_r(), exp_r[1]);
      end
      if (nd == 2 && c == done_t[2] + 85) begin
        bus_r.iValue1 = 16'd42;
        bus_r.iValue2 = 16'd9;
      end
    end
    check("refresh_count", 34'(nd), 34'd4);
    if (nd == 4) begin
      check("refresh_period1", 34'(done_t[2] - done_t[1]), 34'd100);
      check("refresh_period2", 34'(done_t[3] - done_t[2]), 34'd100);
      check("refresh_period3", 34'(done_t[4] - done_t[3]), 34'd100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
